// File: rtl/v_pipe_query_mp_if.sv
// Request/result, state-table and update-pipeline signals of v_pipe_query_mp.
// State word layout (LSB first): entry valids, entry keys, entry sizes, listsize.
interface v_pipe_query_mp_if #(
    parameter int PORTS_N      = 2,
    parameter int UPD_STAGES_N = 4,
    parameter int ID_W         = 8,
    parameter int LEVEL_W      = 3,
    parameter int ENTRIES_N    = 4,
    parameter int KEY_W        = 16,
    parameter int VOL_W        = 16,
    parameter int LS_W         = 8
);
    localparam int PORT_W  = (PORTS_N > 1) ? $clog2(PORTS_N) : 1;
    localparam int STATE_W = ENTRIES_N * (1 + KEY_W + VOL_W) + LS_W;

    logic [PORTS_N-1:0]                    i_lut_vld;
    logic [PORTS_N-1:0][ID_W-1:0]          i_lut_prod_id;
    logic [PORTS_N-1:0][LEVEL_W-1:0]       i_lut_level;
    logic [PORTS_N-1:0]                    o_lut_rdy;

    logic                                  o_lut_vld_r;
    logic [PORT_W-1:0]                     o_lut_port_r;
    logic [KEY_W-1:0]                      o_lut_key;
    logic [VOL_W-1:0]                      o_lut_size;
    logic                                  o_lut_error;
    logic [LS_W-1:0]                       o_lut_listsize;

    logic                                  o_state_ren;
    logic [ID_W-1:0]                       o_state_raddr;
    logic [STATE_W-1:0]                    i_state_rdata;

    logic [UPD_STAGES_N-1:0]               i_upd_vld_r;
    logic [UPD_STAGES_N-1:0][ID_W-1:0]     i_upd_prod_id_r;

    modport slave (
        input  i_lut_vld, i_lut_prod_id, i_lut_level, i_state_rdata, i_upd_vld_r, i_upd_prod_id_r,
        output o_lut_rdy, o_lut_vld_r, o_lut_port_r, o_lut_key, o_lut_size, o_lut_error,
               o_lut_listsize, o_state_ren, o_state_raddr
    );

    modport master (
        output i_lut_vld, i_lut_prod_id, i_lut_level, i_state_rdata, i_upd_vld_r, i_upd_prod_id_r,
        input  o_lut_rdy, o_lut_vld_r, o_lut_port_r, o_lut_key, o_lut_size, o_lut_error,
               o_lut_listsize, o_state_ren, o_state_raddr
    );
endinterface

// File: rtl/v_pipe_query_mp.sv
// Multi-channel product-state lookup with update-pipeline hazard detection.
// Define V_PIPE_QUERY_REPLAY_EN to replay hazarded queries instead of failing them.
module v_pipe_query_mp #(
    parameter int PORTS_N      = 2,
    parameter int UPD_STAGES_N = 4,
    parameter int REPLAY_MAX_N = 7,
    parameter int ID_W         = 8,
    parameter int LEVEL_W      = 3,
    parameter int ENTRIES_N    = 4,
    parameter int KEY_W        = 16,
    parameter int VOL_W        = 16,
    parameter int LS_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    v_pipe_query_mp_if.slave lut
);
    localparam int PORT_W  = (PORTS_N > 1) ? $clog2(PORTS_N) : 1;
    localparam int KEY_OFS = ENTRIES_N;
    localparam int VOL_OFS = ENTRIES_N * (1 + KEY_W);
    localparam int LS_OFS  = ENTRIES_N * (1 + KEY_W + VOL_W);

    logic [PORTS_N-1:0]               occ_r;
    logic [PORTS_N-1:0]               infl_r;
    logic [PORTS_N-1:0][ID_W-1:0]     id_r;
    logic [PORTS_N-1:0][LEVEL_W-1:0]  lvl_r;
    logic [PORT_W-1:0]                rr_r;
    logic                             s1_vld_r;
    logic                             s1_busy_r;
    logic [PORT_W-1:0]                s1_port_r;
    logic [ID_W-1:0]                  s1_id_r;
    logic [LEVEL_W-1:0]               s1_lvl_r;

    logic [PORTS_N-1:0]               busy_s;
    logic [PORTS_N-1:0]               elig_s;
    logic [PORTS_N-1:0]               release_s;
    logic [PORTS_N-1:0]               rdy_s;
    logic [PORTS_N-1:0]               accept_s;
    logic                             grant_vld_s;
    logic [PORT_W-1:0]                grant_s;
    logic [PORT_W-1:0]                rr_next_s;
    logic                             was_busy_s;
    logic                             complete_s;
    logic                             ent_vld_s;
    logic [KEY_W-1:0]                 key_s;
    logic [VOL_W-1:0]                 size_s;

`ifdef V_PIPE_QUERY_REPLAY_EN
    localparam int CNT_W = 4;
    logic [PORTS_N-1:0][CNT_W-1:0]    cnt_r;
    logic [PORTS_N-1:0]               forced_s;
    logic                             s1_forced_r;
`endif

    // Per-channel hazard: held ID matches any valid update-pipeline stage
    always_comb begin
        busy_s = '0;
        for (int p = 0; p < PORTS_N; p++) begin
            for (int k = 0; k < UPD_STAGES_N; k++) begin
                busy_s[p] = busy_s[p] |
                            (lut.i_upd_vld_r[k] & (lut.i_upd_prod_id_r[k] == id_r[p]));
            end
        end
    end

    // Channel eligibility for issue
    always_comb begin
        elig_s = '0;
        for (int p = 0; p < PORTS_N; p++) begin
`ifdef V_PIPE_QUERY_REPLAY_EN
            forced_s[p] = (cnt_r[p] == CNT_W'(REPLAY_MAX_N));
            elig_s[p]   = occ_r[p] & ~infl_r[p] & (~busy_s[p] | forced_s[p]);
`else
            elig_s[p]   = occ_r[p] & ~infl_r[p];
`endif
        end
    end

    // Round-robin pick; descending scan so the channel nearest rr_r wins
    always_comb begin
        int idx;
        idx         = 0;
        grant_vld_s = 1'b0;
        grant_s     = '0;
        for (int i = PORTS_N - 1; i >= 0; i--) begin
            idx         = (int'(rr_r) + i) % PORTS_N;
            grant_vld_s = elig_s[idx] ? 1'b1 : grant_vld_s;
            grant_s     = elig_s[idx] ? PORT_W'(idx) : grant_s;
        end
        rr_next_s = (int'(grant_s) == PORTS_N - 1) ? '0 : grant_s + PORT_W'(1);
    end

    // S1 hazard recheck and completion decision
    always_comb begin
        was_busy_s = s1_vld_r & lut.i_upd_vld_r[0] & (lut.i_upd_prod_id_r[0] == s1_id_r);
`ifdef V_PIPE_QUERY_REPLAY_EN
        complete_s = s1_vld_r & (~was_busy_s | s1_forced_r);
`else
        complete_s = s1_vld_r;
`endif
    end

    // Entry select by level; levels beyond the table never match and read as invalid
    always_comb begin
        key_s     = lut.i_state_rdata[KEY_OFS +: KEY_W];
        size_s    = lut.i_state_rdata[VOL_OFS +: VOL_W];
        ent_vld_s = 1'b0;
        for (int e = 0; e < ENTRIES_N; e++) begin
            key_s     = (s1_lvl_r == LEVEL_W'(e)) ? lut.i_state_rdata[KEY_OFS + e*KEY_W +: KEY_W] : key_s;
            size_s    = (s1_lvl_r == LEVEL_W'(e)) ? lut.i_state_rdata[VOL_OFS + e*VOL_W +: VOL_W] : size_s;
            ent_vld_s = (s1_lvl_r == LEVEL_W'(e)) ? lut.i_state_rdata[e] : ent_vld_s;
        end
    end

    // Holding-register release: at issue, or only at result when replay is enabled
    always_comb begin
        release_s = '0;
        for (int p = 0; p < PORTS_N; p++) begin
`ifdef V_PIPE_QUERY_REPLAY_EN
            release_s[p] = complete_s & (s1_port_r == PORT_W'(p));
`else
            release_s[p] = grant_vld_s & (grant_s == PORT_W'(p));
`endif
        end
    end

    assign rdy_s              = ~occ_r | release_s;
    assign accept_s           = lut.i_lut_vld & rdy_s;
    assign lut.o_lut_rdy      = rdy_s;
    assign lut.o_state_ren    = grant_vld_s;
    assign lut.o_state_raddr  = id_r[grant_s];
    assign lut.o_lut_vld_r    = complete_s & ~rst;
    assign lut.o_lut_port_r   = s1_port_r;
    assign lut.o_lut_key      = key_s;
    assign lut.o_lut_size     = size_s;
    assign lut.o_lut_error    = s1_busy_r | was_busy_s | ~ent_vld_s;
    assign lut.o_lut_listsize = lut.i_state_rdata[LS_OFS +: LS_W];

    // Holding registers, arbiter pointer and S1 stage
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r     <= '0;
            infl_r    <= '0;
            id_r      <= '0;
            lvl_r     <= '0;
            rr_r      <= '0;
            s1_vld_r  <= 1'b0;
            s1_busy_r <= 1'b0;
            s1_port_r <= '0;
            s1_id_r   <= '0;
            s1_lvl_r  <= '0;
`ifdef V_PIPE_QUERY_REPLAY_EN
            cnt_r       <= '0;
            s1_forced_r <= 1'b0;
`endif
        end else begin
            if (grant_vld_s) begin
                rr_r <= rr_next_s;
            end
            s1_vld_r  <= grant_vld_s;
            s1_busy_r <= busy_s[grant_s];
            s1_port_r <= grant_s;
            s1_id_r   <= id_r[grant_s];
            s1_lvl_r  <= lvl_r[grant_s];
`ifdef V_PIPE_QUERY_REPLAY_EN
            s1_forced_r <= forced_s[grant_s];
`endif
            for (int p = 0; p < PORTS_N; p++) begin
                if (accept_s[p]) begin
                    occ_r[p]  <= 1'b1;
                    infl_r[p] <= 1'b0;
                    id_r[p]   <= lut.i_lut_prod_id[p];
                    lvl_r[p]  <= lut.i_lut_level[p];
`ifdef V_PIPE_QUERY_REPLAY_EN
                    cnt_r[p]  <= '0;
`endif
                end else if (release_s[p]) begin
                    occ_r[p]  <= 1'b0;
                    infl_r[p] <= 1'b0;
`ifdef V_PIPE_QUERY_REPLAY_EN
                    cnt_r[p]  <= '0;
                end else if (grant_vld_s && (grant_s == PORT_W'(p))) begin
                    infl_r[p] <= 1'b1;
                end else if (s1_vld_r && (s1_port_r == PORT_W'(p))) begin
                    // Hazard seen in S1: back to eligible without a result
                    infl_r[p] <= 1'b0;
                    cnt_r[p]  <= forced_s[p] ? cnt_r[p] : cnt_r[p] + CNT_W'(1);
                end else if (occ_r[p] && !infl_r[p] && busy_s[p] && !forced_s[p]) begin
                    cnt_r[p]  <= cnt_r[p] + CNT_W'(1);
`endif
                end
            end
        end
    end
endmodule
